// File: rtl/three_phase_sine_sched_pkg.sv
// three_phase_sine_sched_pkg: shared types, widths and defaults for the three-phase sine scheduler
package three_phase_sine_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH_A = 3'd1,
        ST_PH_B = 3'd2,
        ST_PH_C = 3'd3,
        ST_UPD  = 3'd4
    } state_e;

    localparam int ANG_W        = 8;
    localparam int SINE_W       = 9;
    localparam int DUTY_W       = 9;
    localparam int MID_DEF      = 256;
    localparam int PH_B_OFS_DEF = 85;
    localparam int PH_C_OFS_DEF = 171;

    // Two's-complement sine to offset-binary duty: sign-extend, add 256, keep 9 bits.
    // Out-of-range -256 wraps to 0 on purpose (no clamping).
    function automatic logic [DUTY_W-1:0] to_offset_bin(input logic [SINE_W-1:0] s);
        logic [SINE_W:0] ext;
        ext = {s[SINE_W-1], s} + (SINE_W+1)'(256);
        return ext[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/three_phase_sine_sched_phase_accum.sv
// phase_accum: DDS phase accumulator, adds FTW on an update strobe, cleared while disabled
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : synchronous clear (run enable low)
//   upd_i          : add ftw_i this edge
//   ftw_i          : frequency tuning word
//   ang_o          : top ANG_W bits of the accumulator (table angle)
module phase_accum #(
    parameter int ACC_W = 24,
    parameter int ANG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic [ACC_W-1:0] ftw_i,
    output logic [ANG_W-1:0] ang_o
);

    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb acc_d = clr_i ? '0 : upd_i ? acc_q + ftw_i : acc_q;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) acc_q <= '0;
        else          acc_q <= acc_d;

    assign ang_o = acc_q[ACC_W-1 -: ANG_W];

endmodule

// File: rtl/three_phase_sine_sched.sv
// three_phase_sine_sched: time-shares one sine LUT across phases A/B/C and publishes PWM duty words
//   clk_i, rst_n_i   : clock, async active-low reset
//   enable_i         : run enable; low forces idle, midpoint duties, accumulator clear
//   sync_i           : PWM period start pulse, requests a sample set
//   ftw_i            : frequency tuning word, applied at the update step
//   lut_theta_o      : registered angle to the external sine table
//   lut_sine_i       : two's-complement table result for lut_theta_o
//   duty_a/b/c_o     : offset-binary duty words
//   duty_valid_o     : one-cycle pulse when duties were updated
//   busy_o           : high outside IDLE
//   overrun_o        : one-cycle pulse when a SYNC was dropped while busy
module three_phase_sine_sched
    import three_phase_sine_sched_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter int PH_B_OFS = PH_B_OFS_DEF,
    parameter int PH_C_OFS = PH_C_OFS_DEF,
    parameter int MID      = MID_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              sync_i,
    input  logic [ACC_W-1:0]  ftw_i,
    output logic [ANG_W-1:0]  lut_theta_o,
    input  logic [SINE_W-1:0] lut_sine_i,
    output logic [DUTY_W-1:0] duty_a_o,
    output logic [DUTY_W-1:0] duty_b_o,
    output logic [DUTY_W-1:0] duty_c_o,
    output logic              duty_valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam logic [ANG_W-1:0]  OFS_B = ANG_W'(PH_B_OFS);
    localparam logic [ANG_W-1:0]  OFS_C = ANG_W'(PH_C_OFS);
    localparam logic [DUTY_W-1:0] MID_V = DUTY_W'(MID);

    state_e            state_q, state_d;
    logic [ANG_W-1:0]  ang, theta_q, theta_d;
    logic [DUTY_W-1:0] sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
    logic [DUTY_W-1:0] da_q, da_d, db_q, db_d, dc_q, dc_d;
    logic              valid_q, valid_d, ovr_q, ovr_d, busy;

    assign busy = state_q != ST_IDLE;

    // Accumulator only moves at UPD, so ANG is stable across the whole A/B/C walk.
    phase_accum #(.ACC_W(ACC_W), .ANG_W(ANG_W)) u_phase_accum (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (!enable_i),
        .upd_i   (enable_i && state_q == ST_UPD),
        .ftw_i   (ftw_i),
        .ang_o   (ang)
    );

    // Each capture state reads the sine for the angle issued one edge earlier
    // while issuing the next phase's angle.
    always_comb begin
        state_d = state_q;
        theta_d = theta_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shc_d   = shc_q;
        da_d    = da_q;
        db_d    = db_q;
        dc_d    = dc_q;
        valid_d = 1'b0;
        ovr_d   = enable_i && sync_i && busy;
        if (!enable_i) begin
            state_d = ST_IDLE;
            theta_d = '0;
            sha_d   = MID_V;
            shb_d   = MID_V;
            shc_d   = MID_V;
            da_d    = MID_V;
            db_d    = MID_V;
            dc_d    = MID_V;
        end else begin
            case (state_q)
                ST_IDLE: if (sync_i) begin
                    state_d = ST_PH_A;
                    theta_d = ang;
                end
                ST_PH_A: begin
                    sha_d   = to_offset_bin(lut_sine_i);
                    theta_d = ang + OFS_B;
                    state_d = ST_PH_B;
                end
                ST_PH_B: begin
                    shb_d   = to_offset_bin(lut_sine_i);
                    theta_d = ang + OFS_C;
                    state_d = ST_PH_C;
                end
                ST_PH_C: begin
                    shc_d   = to_offset_bin(lut_sine_i);
                    state_d = ST_UPD;
                end
                ST_UPD: begin
                    da_d    = sha_q;
                    db_d    = shb_q;
                    dc_d    = shc_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            theta_q <= '0;
            sha_q   <= MID_V;
            shb_q   <= MID_V;
            shc_q   <= MID_V;
            da_q    <= MID_V;
            db_q    <= MID_V;
            dc_q    <= MID_V;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            theta_q <= theta_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shc_q   <= shc_d;
            da_q    <= da_d;
            db_q    <= db_d;
            dc_q    <= dc_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end

    assign lut_theta_o  = theta_q;
    assign duty_a_o     = da_q;
    assign duty_b_o     = db_q;
    assign duty_c_o     = dc_q;
    assign duty_valid_o = valid_q;
    assign busy_o       = busy;
    assign overrun_o    = ovr_q;

endmodule
